// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-tick divider, h/v counters, active-low syncs, frame flag and rgb blanking.
// Optional build macro VGA_SYNC_ALIGN_EN re-registers vga_rgb/hsync/vsync on the pixel tick.
module vga_sync_gen #(
    parameter int SCREEN_WIDTH = 10,
    parameter int PIXEL_WIDTH  = 12,
    parameter int CLK_DIV      = 4,
    parameter int H_DISPLAY    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_DISPLAY    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [PIXEL_WIDTH-1:0]  rgb_in,
    output logic                    p_tick,
    output logic [SCREEN_WIDTH-1:0] x,
    output logic [SCREEN_WIDTH-1:0] y,
    output logic                    video_on,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    frame_start,
    output logic [PIXEL_WIDTH-1:0]  vga_rgb
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]        DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]        DIV_ONE = DIV_W'(1);
    localparam logic [SCREEN_WIDTH-1:0] H_MAX   = SCREEN_WIDTH'(H_TOTAL - 1);
    localparam logic [SCREEN_WIDTH-1:0] V_MAX   = SCREEN_WIDTH'(V_TOTAL - 1);
    localparam logic [SCREEN_WIDTH-1:0] CNT_ONE = SCREEN_WIDTH'(1);
    // Sync windows compared at 32 bits so an end bound of 2**SCREEN_WIDTH cannot wrap.
    localparam logic [31:0] H_DISP_W = 32'(H_DISPLAY);
    localparam logic [31:0] V_DISP_W = 32'(V_DISPLAY);
    localparam logic [31:0] H_SS     = 32'(H_DISPLAY + H_FRONT);
    localparam logic [31:0] H_SE     = 32'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [31:0] V_SS     = 32'(V_DISPLAY + V_FRONT);
    localparam logic [31:0] V_SE     = 32'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0]        div_cnt_r;
    logic                    p_tick_r;
    logic [SCREEN_WIDTH-1:0] x_r;
    logic [SCREEN_WIDTH-1:0] y_r;
    logic                    hsync_r;
    logic                    vsync_r;
    logic                    frame_start_r;
    logic [SCREEN_WIDTH-1:0] x_next_s;
    logic [SCREEN_WIDTH-1:0] y_next_s;
    logic                    hsync_next_s;
    logic                    vsync_next_s;
    logic                    frame_wrap_s;
    logic                    video_on_s;

    // Sys-clock divider counting 0..CLK_DIV-1.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt_r <= '0;
        end else if (div_cnt_r == DIV_MAX) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
        end
    end

    // Registered pixel tick, high the cycle after the divider's last count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            p_tick_r <= 1'b0;
        end else begin
            p_tick_r <= (div_cnt_r == DIV_MAX);
        end
    end

    // Next counter values; y only steps on the x wrap and both wrap together at end of frame.
    always_comb begin
        x_next_s     = x_r;
        y_next_s     = y_r;
        frame_wrap_s = 1'b0;
        if (p_tick_r) begin
            if (x_r == H_MAX) begin
                x_next_s = '0;
                if (y_r == V_MAX) begin
                    y_next_s     = '0;
                    frame_wrap_s = 1'b1;
                end else begin
                    y_next_s = y_r + CNT_ONE;
                end
            end else begin
                x_next_s = x_r + CNT_ONE;
            end
        end else begin
            x_next_s = x_r;
            y_next_s = y_r;
        end
    end

    // Sync levels decoded from the next counts so the registered syncs line up with x/y.
    always_comb begin
        hsync_next_s = ~((32'(x_next_s) >= H_SS) && (32'(x_next_s) < H_SE));
        vsync_next_s = ~((32'(y_next_s) >= V_SS) && (32'(y_next_s) < V_SE));
    end

    // Counter, sync and frame-flag registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x_r           <= '0;
            y_r           <= '0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            x_r           <= x_next_s;
            y_r           <= y_next_s;
            hsync_r       <= hsync_next_s;
            vsync_r       <= vsync_next_s;
            frame_start_r <= frame_wrap_s;
        end
    end

    // Visible-area decode straight from the counter registers.
    always_comb begin
        video_on_s = (32'(x_r) < H_DISP_W) && (32'(y_r) < V_DISP_W);
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic [PIXEL_WIDTH-1:0] vga_rgb_r;
    logic                   hsync_d_r;
    logic                   vsync_d_r;

    // One-pixel output stage matching a registered pixel path downstream.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vga_rgb_r <= '0;
            hsync_d_r <= 1'b1;
            vsync_d_r <= 1'b1;
        end else if (p_tick_r) begin
            vga_rgb_r <= video_on_s ? rgb_in : '0;
            hsync_d_r <= hsync_r;
            vsync_d_r <= vsync_r;
        end else begin
            vga_rgb_r <= vga_rgb_r;
            hsync_d_r <= hsync_d_r;
            vsync_d_r <= vsync_d_r;
        end
    end

    assign vga_rgb = vga_rgb_r;
    assign hsync   = hsync_d_r;
    assign vsync   = vsync_d_r;
`else
    logic [PIXEL_WIDTH-1:0] vga_rgb_s;

    // Blank the generator's colour outside the visible area.
    always_comb begin
        if (video_on_s) begin
            vga_rgb_s = rgb_in;
        end else begin
            vga_rgb_s = '0;
        end
    end

    assign vga_rgb = vga_rgb_s;
    assign hsync   = hsync_r;
    assign vsync   = vsync_r;
`endif

    assign p_tick      = p_tick_r;
    assign x           = x_r;
    assign y           = y_r;
    assign video_on    = video_on_s;
    assign frame_start = frame_start_r;

endmodule
